data_mem_write_buffer: RTL and testbench
========================================

# data_mem_write_buffer

Store/write buffer between the execute-side load/store port and the 32-word data memory. Stores are queued in a small FIFO and drained into the memory write port one per cycle. Loads go straight to the memory read port, with forwarding from the youngest matching buffered store. The load result is registered, so the requester sees it one cycle after issue.

## Interface
- DEPTH, 4, number of store entries; power of two, ≥2
- ADDR_W, 5, word-address width (matches the 32-word memory)
- DATA_W, 32, data width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  request present this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  load data valid (registered)
- rsp_data  out  DATA_W  load data (registered)
- drain_en  in  1  permits draining to memory this cycle
- empty  out  1  buffer holds no stores
- mem_addr  out  ADDR_W  memory write address (head entry)
- mem_wdata  out  DATA_W  memory write data (head entry)
- mem_write  out  1  memory write strobe
- mem_addr_re  out  ADDR_W  memory read address (= req_addr)
- mem_read  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr_re

## Operation
- Storage: circular FIFO of {addr, data}.
  - Pointers wr_ptr/rd_ptr of clog2(DEPTH) bits wrap modulo DEPTH.
  - count is clog2(DEPTH+1) bits, range 0..DEPTH.
- req_ready:
  - Loads: always 1.
  - Stores: count < DEPTH. A store is not accepted at full, even if a drain pops that same cycle.
- Store accept: entry written at wr_ptr, wr_ptr+1.
- Drain:
  - When count>0 && drain_en: mem_write=1, and mem_addr/mem_wdata come from the head entry.
  - At the edge: rd_ptr+1.
  - mem_write=0 whenever empty or drain_en=0; mem_addr/mem_wdata are don't-care then.
- Simultaneous accept + drain: count unchanged, both pointers advance.
- Load:
  - mem_read = req_valid && !req_write; mem_addr_re = req_addr (combinational).
  - At the edge, rsp_data captures the youngest valid buffer entry whose addr equals req_addr, else mem_rdata; rsp_valid=1 for one cycle.
  - "Youngest" is the matching entry closest to wr_ptr-1.
  - The entry being drained in the same cycle still counts as valid for matching.
- No load issued: rsp_valid=0 next cycle; rsp_data holds its last value.
- Duplicate addresses in the buffer are permitted. Drain order preserves program order, so the last store wins in memory.

## Timing
- Reset (rst=0, asynchronous): count=0, wr_ptr=rd_ptr=0, rsp_valid=0, rsp_data=0.
  - Hence empty=1, mem_write=0, req_ready=1.
  - Entry contents are not reset.
- Reset mid-operation drops all buffered stores; memory keeps whatever was already drained.
- Store-to-memory latency: at least 1 cycle after acceptance (the entry is visible at head the cycle after enqueue when the buffer was empty).
- Load latency: exactly 1 cycle (issue cycle N, rsp_valid in N+1).
- Back-to-back loads: one response per cycle.
- req_ready, mem_write, mem_read and empty are combinational from state and inputs. rsp_* are registered.

## Structure
- Shared package mem_pkg:
  - ADDR_W and DATA_W constants.
  - wb_entry_t struct {addr, data}.
- One sub-module, wb_fifo: parameterised storage array, pointers, count, full/empty, with head output and a flat entry-valid view for the forwarding search.
- Top level holds the forwarding priority search, the response register and the memory-port glue.

## Test plan
- Reset, then a load from addr 3 with mem_rdata=0 -> rsp_valid=1 one cycle later, rsp_data=0; empty=1, mem_write=0.
- drain_en=0, stores (5,0xA), (5,0xB), then a load of addr 5 -> rsp_data=0xB (youngest forward), mem_write stays 0.
- drain_en=0, four stores -> req_ready=0 with count=4; fifth store held; raise drain_en -> drains in order, one per cycle, mem_write for 4 cycles; fifth store is accepted the cycle after count drops to 3.
- Store and drain in the same cycle with 2 entries queued -> count stays 2; pointers wrap past DEPTH-1 correctly across 10 stores.
- Load to addr 7 in the same cycle that head entry (7,0x55) is draining -> rsp_data=0x55.
- Assert rst=0 with 3 entries queued -> count=0, empty=1, rsp_valid=0 immediately; no further mem_write pulses after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the data-memory write buffer.
// An entry pairs a word address with its store data.
package mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/data_mem_write_buffer_if.sv
// Request/response, drain control and memory-port signals of the write buffer.
// The slave modport is the buffer side; the master modport is the requester/memory side.
interface data_mem_write_buffer_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              drain_en;
  logic              empty;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr_re;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, drain_en, mem_rdata,
    output req_ready, rsp_valid, rsp_data, empty,
           mem_addr, mem_wdata, mem_write, mem_addr_re, mem_read
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, drain_en, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, empty,
           mem_addr, mem_wdata, mem_write, mem_addr_re, mem_read
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular store FIFO: pointers, occupancy count, head entry and a flat
// per-slot valid view used by the load-forwarding search.
module wb_fifo
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output wb_entry_t [DEPTH-1:0] entries_o,
  output logic      [DEPTH-1:0] valid_o,
  output logic      [PW-1:0]    rd_ptr_o,
  output logic                  full_o,
  output logic                  empty_o
);
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  wb_entry_t [DEPTH-1:0] store_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // A push at full is refused even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= push_entry_i;
  end

  // Slot i is occupied when its distance from the head is below the count.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = (CW'(PW'(i) - rd_ptr_q) < count_q);
    end
  end

  assign head_o    = store_q[rd_ptr_q];
  assign entries_o = store_q;
  assign rd_ptr_o  = rd_ptr_q;
endmodule

// File: rtl/data_mem_write_buffer.sv
// Store buffer in front of the 32-word data memory: queues stores, drains one per
// cycle, and answers loads one cycle later with youngest-store forwarding.
module data_mem_write_buffer
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input logic                     clk,
  input logic                     rst,
  data_mem_write_buffer_if.slave  bus
);
  wb_entry_t             head, push_entry;
  wb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] valid;
  logic      [PW-1:0]    rd_ptr;
  logic                  full, fifo_empty, load;
  logic      [PW-1:0]    idx;
  logic      [DATA_W-1:0] fwd_data;
  logic                  rsp_valid_q, rsp_valid_d;
  logic      [DATA_W-1:0] rsp_data_q, rsp_data_d;

  assign push_entry.addr = bus.req_addr;
  assign push_entry.data = bus.req_wdata;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (bus.req_valid && bus.req_write),
    .push_entry_i (push_entry),
    .pop_i        (bus.drain_en),
    .head_o       (head),
    .entries_o    (entries),
    .valid_o      (valid),
    .rd_ptr_o     (rd_ptr),
    .full_o       (full),
    .empty_o      (fifo_empty)
  );

  assign bus.req_ready   = !bus.req_write || !full;
  assign bus.empty       = fifo_empty;
  assign bus.mem_write   = bus.drain_en && !fifo_empty;
  assign bus.mem_addr    = head.addr;
  assign bus.mem_wdata   = head.data;
  assign load            = bus.req_valid && !bus.req_write;
  assign bus.mem_read    = load;
  assign bus.mem_addr_re = bus.req_addr;

  // Walk oldest to youngest so the last match (closest to wr_ptr-1) wins.
  // The head being drained this cycle is still valid here.
  always_comb begin
    idx      = '0;
    fwd_data = bus.mem_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (valid[idx] && (entries[idx].addr == bus.req_addr)) fwd_data = entries[idx].data;
    end
  end

  always_comb begin
    rsp_valid_d = load;
    rsp_data_d  = load ? fwd_data : rsp_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_data_mem_write_buffer.sv
// Directed bench for data_mem_write_buffer with a reference buffer/memory model
// and a response scoreboard queue.
module tb_data_mem_write_buffer;
  import mem_pkg::*;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  data_mem_write_buffer_if bus ();

  data_mem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  logic [DATA_W-1:0] tb_mem  [32];
  logic [DATA_W-1:0] ref_mem [32];
  wb_entry_t         ref_q[$];
  logic [DATA_W-1:0] exp_rsp_q[$];
  logic [DATA_W-1:0] last_rsp;

  assign bus.mem_rdata = tb_mem[bus.mem_addr_re];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic de, output logic acc);
    logic              ld, exp_drain, wr_obs;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd, exp_fwd;
    wb_entry_t         hd, ne;
    @(negedge clk);
    bus.req_valid = v; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.drain_en = de;
    #1;
    ld        = v && !w;
    exp_drain = de && (ref_q.size() > 0);
    chk("req_ready", bus.req_ready, (!w || ref_q.size() < DEPTH));
    chk("empty", bus.empty, ref_q.size() == 0);
    chk("mem_write", bus.mem_write, exp_drain);
    chk("mem_read", bus.mem_read, ld);
    if (ld) chk("mem_addr_re", bus.mem_addr_re, a);
    hd = '0;
    if (exp_drain) begin
      hd = ref_q[0];
      chk("drain_addr", bus.mem_addr, hd.addr);
      chk("drain_data", bus.mem_wdata, hd.data);
    end
    if (ld) begin
      exp_fwd = ref_mem[a];
      foreach (ref_q[i]) if (ref_q[i].addr == a) exp_fwd = ref_q[i].data;
      exp_rsp_q.push_back(exp_fwd);
    end
    acc = v && w && (ref_q.size() < DEPTH);
    if (exp_drain) begin
      ref_mem[hd.addr] = hd.data;
      void'(ref_q.pop_front());
    end
    if (acc) begin
      ne.addr = a; ne.data = d;
      ref_q.push_back(ne);
    end
    wr_obs = bus.mem_write; wa = bus.mem_addr; wd = bus.mem_wdata;
    @(posedge clk);
    #1;
    if (wr_obs === 1'b1) tb_mem[wa] = wd;
    chk("rsp_valid", bus.rsp_valid, ld);
    if (ld) begin
      if (exp_rsp_q.size() == 0) chk("rsp_queue", 32'd1, 32'd0);
      else begin
        last_rsp = exp_rsp_q.pop_front();
        chk("rsp_data", bus.rsp_data, last_rsp);
      end
    end else chk("rsp_hold", bus.rsp_data, last_rsp);
  endtask

  initial begin
    logic acc;
    int   n;
    n_cmp = 0; n_bad = 0; last_rsp = '0;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i]  = (i == 3) ? 32'h0 : 32'h1000 + i;
      ref_mem[i] = tb_mem[i];
    end
    bus.req_valid = 0; bus.req_write = 1; bus.req_addr = '0; bus.req_wdata = '0; bus.drain_en = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    rst_n = 1'b1;

    // Plain load from memory after reset
    step(1, 0, 5'd3, 0, 0, acc);

    // Youngest-store forwarding on duplicate addresses
    step(1, 1, 5'd5, 32'hA, 0, acc);
    step(1, 1, 5'd5, 32'hB, 0, acc);
    step(1, 0, 5'd5, 0, 0, acc);
    step(1, 0, 5'd6, 0, 0, acc);
    step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);
    step(1, 0, 5'd5, 0, 0, acc);

    // Fill to full, stall a fifth store, then drain
    for (int i = 0; i < 4; i++) step(1, 1, 5'(10 + i), 32'h100 + i, 0, acc);
    step(1, 1, 5'd20, 32'hF0, 0, acc);
    chk("store_at_full", acc, 1'b0);
    n = 0; acc = 0;
    while (!acc && n < 8) begin
      n++;
      step(1, 1, 5'd20, 32'hF0, 1, acc);
    end
    chk("fifth_accept_cycle", n, 2);
    n = 0;
    while (ref_q.size() > 0 && n < 8) begin n++; step(0, 0, 0, 0, 1, acc); end
    chk("drain_bound", ref_q.size(), 0);
    step(0, 0, 0, 0, 1, acc);

    // Simultaneous store and drain with two queued; pointers wrap
    step(1, 1, 5'd16, 32'h2000, 0, acc);
    step(1, 1, 5'd17, 32'h2001, 0, acc);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 5'(18 + i), 32'h2100 + i, 1, acc);
      chk("wrap_accept", acc, 1'b1);
      chk("wrap_count", ref_q.size(), 2);
    end
    step(1, 0, 5'd27, 0, 1, acc);
    step(0, 0, 0, 0, 1, acc);

    // Load hits the entry draining in the same cycle; back-to-back loads
    step(1, 1, 5'd7, 32'h55, 0, acc);
    step(1, 0, 5'd7, 0, 1, acc);
    step(1, 0, 5'd7, 0, 0, acc);
    step(1, 0, 5'd3, 0, 0, acc);

    // Reset with three stores queued
    step(1, 1, 5'd1, 32'hC1, 0, acc);
    step(1, 1, 5'd2, 32'hC2, 0, acc);
    step(1, 1, 5'd4, 32'hC4, 0, acc);
    step(1, 0, 5'd1, 0, 0, acc);
    bus.req_valid = 0; bus.drain_en = 1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", bus.empty, 1'b1);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_rsp_data", bus.rsp_data, 32'h0);
    chk("mid_rst_mem_write", bus.mem_write, 1'b0);
    ref_q.delete(); exp_rsp_q.delete(); last_rsp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0, 1, acc);

    for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), tb_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
